// File: rtl/proc_pkg.sv
// Shared fetch-stage types: FSM state encoding, buffer entry layout, NOP word.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package proc_pkg;

  // Fetch sequencer states. REQ issues unconditionally because it is only
  // entered with an empty buffer (after reset or a quiet redirect).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  // Canonical RV NOP (addi x0, x0, 0), available to stages that need a bubble.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int ENTRY_W = 96;

  // One instruction buffer slot: fetched word plus the PC it came from.
  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO holding fetched instructions between imem and decode.
// Latency: push visible at head on the next cycle; head is read combinationally.
// Backpressure: full blocks push unless a pop happens in the same cycle; flush empties it.
module fetch_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] slots [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = pop && !empty;
  // A pop frees the head slot in the same cycle, so a full FIFO may still take a push.
  assign do_push   = push && (!full || do_pop);
  assign head_data = slots[rd_ptr];

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because occupancy guards every read.
  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: single-outstanding imem requests into a small buffer toward decode.
// Latency: imem response to if_valid is 1 cycle; 1 instr per 2 cycles with a 1-cycle imem.
// Backpressure: id_ready low stalls the head; no request issues without a guaranteed free slot.
module instr_fetch_unit
  import proc_pkg::*;
#(
  parameter logic [63:0] RESET_ADDR = 64'h0,
  parameter int          BUF_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] curAddress,
  input  logic [63:0] nextAddress,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_addr,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [63:0] if_pc,
  input  logic        id_ready
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUF_DEPTH);

  fetch_state_t state;
  fetch_state_t state_nxt;
  logic [63:0]  pc_q;
  logic [63:0]  pc_nxt;
  logic         req;
  logic         push;
  logic         pop;
  logic         slot_free;
  logic         fifo_full;
  logic         fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;

  assign pop        = !fifo_empty && id_ready;
  // Only IDLE consults this and IDLE has nothing in flight, so occupancy minus
  // the same-cycle pop must leave room for the one response we are about to request.
  assign slot_free  = !fifo_full || pop;
  assign push_entry = '{instr: imem_rdata, pc: pc_q};

  assign curAddress = pc_q;
  assign imem_addr  = pc_q;
  assign imem_req   = req && !reset;
  assign if_valid   = !fifo_empty;
  assign if_instr   = fifo_empty ? 32'h0 : head_entry.instr;
  assign if_pc      = fifo_empty ? 64'h0 : head_entry.pc;

  // Next-state, request, push and PC selection; redirect overrides every other event.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    req       = 1'b0;
    push      = 1'b0;
    case (state)
      REQ: begin
        req       = 1'b1;
        state_nxt = WAIT;
      end
      IDLE: begin
        if (slot_free) begin
          req       = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          push      = 1'b1;
          pc_nxt    = nextAddress;
          state_nxt = IDLE;
        end
      end
      DROP: begin
        if (imem_rvalid) state_nxt = IDLE;
      end
      default: state_nxt = REQ;
    endcase
    if (redirect_valid) begin
      req    = 1'b0;
      push   = 1'b0;
      pc_nxt = redirect_addr;
      if (state == WAIT || state == DROP) begin
        // A response landing this cycle is the stale one; otherwise wait it out in DROP.
        state_nxt = imem_rvalid ? IDLE : DROP;
      end else begin
        state_nxt = REQ;
      end
    end
  end

  // State and PC registers with synchronous reset into REQ at RESET_ADDR.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= REQ;
      pc_q  <= RESET_ADDR;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Occupancy can never exceed the buffer depth.
  always_ff @(posedge clk) begin
    if (!reset) assert (fifo_count <= DEPTH_CNT);
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_ADDR, default 64'h0, the PC value loaded on reset.
REQ-002 The block SHALL have parameter BUF_DEPTH, default 2, the instruction buffer depth (power of two, at least 2).
REQ-003 The block SHALL use port clk, input, 1 bit, as its single clock, with all state updated on the rising edge.
REQ-004 The block SHALL use port reset, input, 1 bit, as its synchronous active-high reset.
REQ-005 The block SHALL have port curAddress, output, 64 bits, the current PC register, fed to the program counter logic.
REQ-006 The block SHALL have port nextAddress, input, 64 bits, the next PC computed by the program counter logic from curAddress.
REQ-007 The block SHALL have port redirect_valid, input, 1 bit, a late-stage redirect (mispredict or exception).
REQ-008 The block SHALL have port redirect_addr, input, 64 bits, the redirect target.
REQ-009 The block SHALL have port imem_req, output, 1 bit, instruction memory request strobe.
REQ-010 The block SHALL have port imem_addr, output, 64 bits, the instruction memory address.
REQ-011 The block SHALL have port imem_rvalid, input, 1 bit, instruction memory response valid.
REQ-012 The block SHALL have port imem_rdata, input, 32 bits, the instruction word.
REQ-013 The block SHALL have port if_valid, output, 1 bit, buffer head valid toward decode.
REQ-014 The block SHALL have port if_instr, output, 32 bits, the buffer head instruction.
REQ-015 The block SHALL have port if_pc, output, 64 bits, the buffer head PC.
REQ-016 The block SHALL have port id_ready, input, 1 bit, decode accepts the head.

Function
REQ-017 The block SHALL keep at most one imem request outstanding; imem_req is a one-cycle pulse, with imem_addr equal to curAddress in that cycle.
REQ-018 The block SHALL implement FSM states IDLE, REQ, WAIT, DROP.
- IDLE: if the buffer has a free slot, or will after a same-cycle pop, pulse imem_req and go to WAIT; otherwise hold.
- WAIT: on imem_rvalid, push {imem_rdata, curAddress}, load PC with nextAddress, and go to IDLE.
- DROP: on imem_rvalid, discard the response and go to IDLE.
- REQ: a one-cycle state entered after reset and after a redirect that is not in flight; it issues the request and goes to WAIT.
REQ-019 The block SHALL issue a request in at most one cycle after a free slot appears, giving a sustained throughput of one instruction per 2 cycles with a 1-cycle-latency memory.
REQ-020 When redirect_valid is high, the block SHALL flush the buffer, set if_valid low next cycle, and load PC with redirect_addr.
- If a request is outstanding and imem_rvalid is low, go to DROP.
- If imem_rvalid is high in the same cycle, drop that response and go to IDLE.
- Redirect has priority over every other event.
REQ-021 The buffer SHALL be a FIFO; pop happens when if_valid and id_ready are both high; push and pop in the same cycle are legal when full.
REQ-022 The block SHALL never overflow the buffer: no request is issued unless the occupancy, plus in-flight requests, minus the same-cycle pop, is less than BUF_DEPTH.
REQ-023 If imem_rvalid arrives in IDLE with no request outstanding, the block SHALL ignore it.
REQ-024 PC arithmetic SHALL be full 64-bit with natural wrap-around from 64'hFFFF_FFFF_FFFF_FFFC; the block performs no alignment check.
REQ-025 if_instr and if_pc SHALL be stable while if_valid is high and id_ready is low.

Reset
REQ-026 On reset, the block SHALL set curAddress to RESET_ADDR, empty the buffer, set if_valid=0 and imem_req=0, and enter REQ.
REQ-027 Reset mid-request SHALL discard the outstanding response; a response arriving in the first cycle after reset is ignored.
REQ-028 if_instr and if_pc SHALL read 0 while the buffer is empty.

Structure
REQ-029 FSM state encodings and the NOP encoding SHALL reside in the shared package proc_pkg.
REQ-030 The buffer SHALL be a sub-module fetch_fifo (parameter WIDTH=96, DEPTH=BUF_DEPTH) providing push, pop, full, empty, and count.
REQ-031 The program counter adder and branch logic SHALL stay external; this block only registers nextAddress.

Verification
REQ-032 Reset with RESET_ADDR=0 and a 1-cycle memory returning 32'hAAAA0000+addr: the first request is at address 0, and if_valid rises with if_pc=0 and if_instr=32'hAAAA0000.
REQ-033 With id_ready=0 held and nextAddress=curAddress+4: exactly 2 instructions (PC 0 and 4) are buffered, and imem_req stays low until id_ready rises.
REQ-034 Redirect to 64'h100 while a 3-cycle-latency response is outstanding: the stale response is dropped, and the next if_pc is 64'h100.
REQ-035 Redirect coincident with imem_rvalid and a full buffer pop: the buffer is empty the next cycle, with no push of the stale word.
REQ-036 curAddress=64'hFFFF_FFFF_FFFF_FFFC with nextAddress=curAddress+4: the next if_pc is 64'h0.
REQ-037 Reset asserted during WAIT, with imem_rvalid arriving one cycle later: the response is ignored, and the first delivered instruction has if_pc=RESET_ADDR.
